module_fetch_unit: RTL and testbench

//  Instruction fetch stage between program counter/IRAM and the control unit.
//  - Owns the fetch PC and drives the synchronous IRAM read address.
//  - Buffers returned instructions, tagged with their PC, in a small prefetch queue.
//  - Hands instructions to the control unit over a valid/ready handshake.
//  - Accepts redirects (jump, branch, external address load) that flush the queue.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/module_fetch_unit_if.sv | 25 ++
 rtl/module_fetch_fifo.sv | 42 ++++
 rtl/module_fetch_unit.sv | 48 ++++
 tb/tb_module_fetch_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, reset address, NOP encoding and fetch queue entry type
package cpu_pkg;
  localparam int DEF_WORD_SIZE = 8;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_RESET_ADDR = 0;
  localparam logic [DEF_WORD_SIZE-1:0] NOP = 8'h00;
  typedef struct packed {
    logic [DEF_WORD_SIZE-1:0] instr;
    logic [DEF_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/module_fetch_unit_if.sv
// module_fetch_unit_if: redirect, IRAM and control-unit handshake signals of the fetch stage
interface module_fetch_unit_if import cpu_pkg::*; #(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH = 4
);
  logic redirect_en;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic [ADDR_WIDTH-1:0] iram_addr;
  logic [WORD_SIZE-1:0] iram_data;
  logic instr_valid;
  logic instr_ready;
  logic [WORD_SIZE-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic [$clog2(DEPTH):0] level;
  modport slave (
    input redirect_en, redirect_addr, iram_data, instr_ready,
    output iram_addr, instr_valid, instr, instr_pc, pc_out, level
  );
  modport master (
    output redirect_en, redirect_addr, iram_data, instr_ready,
    input iram_addr, instr_valid, instr, instr_pc, pc_out, level
  );
endinterface

// File: rtl/module_fetch_fifo.sv
// module_fetch_fifo: circular prefetch queue with wrap-bit pointers and synchronous clear
module module_fetch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic valid,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last;
  logic [PW:0] wr, rd;
  logic wen, ren;
  // when empty the output shows the last head seen rather than a stale slot
  always_comb begin
    level = wr - rd;
    valid = level != '0;
    dout = valid ? mem[rd[PW-1:0]] : last;
    wen = push && !clear;
    ren = pop && valid && !clear;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr <= '0;
      rd <= '0;
      last <= '0;
    end else begin
      wr <= clear ? '0 : wr + (PW+1)'(wen);
      rd <= clear ? '0 : rd + (PW+1)'(ren);
      last <= dout;
    end
  always_ff @(posedge clk)
    if (wen) mem[wr[PW-1:0]] <= din;
  assert property (@(posedge clk) disable iff (!reset) !(wen && level == (PW+1)'(DEPTH)));
endmodule

// File: rtl/module_fetch_unit.sv
// module_fetch_unit: fetch PC, synchronous IRAM issue and prefetch queue feeding the control unit
module module_fetch_unit import cpu_pkg::*; #(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(DEF_RESET_ADDR)
) (
  input logic clk,
  input logic reset,
  module_fetch_unit_if.slave bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  logic [ADDR_WIDTH-1:0] fetch_pc, inflight_pc;
  logic inflight, issue, push, pop;
  logic [LW:0] occ;
  logic [WORD_SIZE+ADDR_WIDTH-1:0] head;
  // only issue when the returning word is guaranteed a queue slot
  always_comb begin
    occ = (LW+1)'(bus.level) + (LW+1)'(inflight);
    issue = occ < (LW+1)'(DEPTH) && !bus.redirect_en;
    push = inflight && !bus.redirect_en;
    pop = bus.instr_valid && bus.instr_ready && !bus.redirect_en;
    bus.iram_addr = fetch_pc;
    bus.pc_out = fetch_pc;
    {bus.instr, bus.instr_pc} = head;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fetch_pc <= RESET_ADDR;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else begin
      fetch_pc <= bus.redirect_en ? bus.redirect_addr : issue ? fetch_pc + 1'b1 : fetch_pc;
      inflight <= issue;
      inflight_pc <= issue ? fetch_pc : inflight_pc;
    end
  module_fetch_fifo #(.WIDTH(WORD_SIZE + ADDR_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .clear(bus.redirect_en),
    .push(push),
    .pop(pop),
    .din({bus.iram_data, inflight_pc}),
    .dout(head),
    .valid(bus.instr_valid),
    .level(bus.level)
  );
endmodule

// File: tb/tb_module_fetch_unit.sv
// tb_module_fetch_unit: directed and randomized checks of the fetch stage against an in-order stream model
module tb_module_fetch_unit;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [7:0] iram [256];
  module_fetch_unit_if bus ();
  module_fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.iram_data <= iram[bus.iram_addr];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_addr = '0;
    bus.instr_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.redirect_en = 1'b0;
    bus.redirect_addr = '0;
    bus.instr_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    tests++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
    tests++; if (bus.instr !== 8'h00) begin fails++; $display("FAIL reset_instr got %h want 00", bus.instr); end
    tests++; if (bus.instr_pc !== 8'h00) begin fails++; $display("FAIL reset_instr_pc got %h want 00", bus.instr_pc); end
    tests++; if (bus.level !== 3'd0) begin fails++; $display("FAIL reset_level got %0d want 0", bus.level); end
    tests++; if (bus.pc_out !== 8'h00) begin fails++; $display("FAIL reset_pc_out got %h want 00", bus.pc_out); end
    tests++; if (bus.iram_addr !== 8'h00) begin fails++; $display("FAIL reset_iram_addr got %h want 00", bus.iram_addr); end
  endtask

  task automatic test_stream();
    fetch_entry_t want;
    for (int i = 0; i < 256; i++) iram[i] = 8'(i + 'h10);
    do_reset();
    bus.instr_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      tests++; if (bus.iram_addr !== 8'(k)) begin fails++; $display("FAIL stream_addr k=%0d got %h want %h", k, bus.iram_addr, 8'(k)); end
      tests++; if (bus.instr_valid !== (k >= 2)) begin fails++; $display("FAIL stream_valid k=%0d got %b want %b", k, bus.instr_valid, k >= 2); end
      want = '{instr: iram[8'(k-2)], pc: 8'(k-2)};
      if (k >= 2) begin
        tests++; if ({bus.instr, bus.instr_pc} !== want) begin fails++; $display("FAIL stream_data k=%0d got %h/%h want %h/%h", k, bus.instr, bus.instr_pc, want.instr, want.pc); end
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    repeat (10) @(negedge clk);
    tests++; if (bus.level !== 3'd4) begin fails++; $display("FAIL bp_level got %0d want 4", bus.level); end
    tests++; if (bus.iram_addr !== 8'h04) begin fails++; $display("FAIL bp_addr got %h want 04", bus.iram_addr); end
    tests++; if (bus.instr_valid !== 1'b1) begin fails++; $display("FAIL bp_valid got %b want 1", bus.instr_valid); end
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 30 && n < 8; c++) begin
      if (bus.instr_valid) begin
        tests++; if (bus.instr !== iram[8'(n)] || bus.instr_pc !== 8'(n)) begin fails++; $display("FAIL bp_data got %h/%h want %h/%h", bus.instr, bus.instr_pc, iram[8'(n)], 8'(n)); end
        n++;
      end
      @(negedge clk);
    end
    tests++; if (n != 8) begin fails++; $display("FAIL bp_timeout got %0d want 8 deliveries", n); end
  endtask

  task automatic test_redirect_flush();
    logic [7:0] pc = 8'h80;
    int n = 0;
    do_reset();
    for (int c = 0; c < 20 && bus.level != 3'd3; c++) @(negedge clk);
    tests++; if (bus.level !== 3'd3) begin fails++; $display("FAIL flush_pre_level got %0d want 3", bus.level); end
    bus.redirect_en = 1'b1;
    bus.redirect_addr = 8'h80;
    @(negedge clk);
    tests++; if (bus.level !== 3'd0 || bus.instr_valid !== 1'b0) begin fails++; $display("FAIL flush_clear got level=%0d valid=%b want 0/0", bus.level, bus.instr_valid); end
    tests++; if (bus.pc_out !== 8'h80) begin fails++; $display("FAIL flush_pc got %h want 80", bus.pc_out); end
    bus.redirect_en = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    tests++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL flush_latency1 got %b want 0", bus.instr_valid); end
    @(negedge clk);
    tests++; if (bus.instr_valid !== 1'b1) begin fails++; $display("FAIL flush_latency2 got %b want 1", bus.instr_valid); end
    for (int c = 0; c < 20 && n < 5; c++) begin
      if (bus.instr_valid) begin
        tests++; if (bus.instr !== iram[pc] || bus.instr_pc !== pc) begin fails++; $display("FAIL flush_data got %h/%h want %h/%h", bus.instr, bus.instr_pc, iram[pc], pc); end
        pc++;
        n++;
      end
      @(negedge clk);
    end
    tests++; if (n != 5) begin fails++; $display("FAIL flush_timeout got %0d want 5 deliveries", n); end
  endtask

  task automatic test_wrap();
    logic [7:0] pc = 8'hFE;
    int n = 0;
    do_reset();
    bus.redirect_en = 1'b1;
    bus.redirect_addr = 8'hFE;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.redirect_en = 1'b0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (bus.instr_valid) begin
        tests++; if (bus.instr !== iram[pc] || bus.instr_pc !== pc) begin fails++; $display("FAIL wrap_data got %h/%h want %h/%h", bus.instr, bus.instr_pc, iram[pc], pc); end
        pc++;
        n++;
      end
      @(negedge clk);
    end
    tests++; if (n != 4 || pc !== 8'h02) begin fails++; $display("FAIL wrap_count got %0d next=%h want 4 next=02", n, pc); end
  endtask

  task automatic test_redirect_pop();
    logic [7:0] pc = 8'h20;
    int n = 0;
    do_reset();
    bus.instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (bus.level !== 3'd1 || bus.instr_valid !== 1'b1) begin fails++; $display("FAIL rp_pre got level=%0d valid=%b want 1/1", bus.level, bus.instr_valid); end
    bus.redirect_en = 1'b1;
    bus.redirect_addr = 8'h55;
    @(negedge clk);
    tests++; if (bus.level !== 3'd0 || bus.instr_valid !== 1'b0) begin fails++; $display("FAIL rp_clear got level=%0d valid=%b want 0/0", bus.level, bus.instr_valid); end
    bus.redirect_addr = 8'h20;
    @(negedge clk);
    tests++; if (bus.level !== 3'd0 || bus.pc_out !== 8'h20) begin fails++; $display("FAIL rp_second got level=%0d pc=%h want 0/20", bus.level, bus.pc_out); end
    bus.redirect_en = 1'b0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      if (bus.instr_valid) begin
        tests++; if (bus.instr !== iram[pc] || bus.instr_pc !== pc) begin fails++; $display("FAIL rp_data got %h/%h want %h/%h", bus.instr, bus.instr_pc, iram[pc], pc); end
        pc++;
        n++;
      end
      @(negedge clk);
    end
    tests++; if (n != 5) begin fails++; $display("FAIL rp_timeout got %0d want 5 deliveries", n); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.instr_ready = 1'b1;
    repeat (5) @(negedge clk);
    tests++; if (bus.instr_valid !== 1'b1) begin fails++; $display("FAIL ar_pre_valid got %b want 1", bus.instr_valid); end
    #2 reset = 1'b0;
    #1;
    tests++; if (bus.instr_valid !== 1'b0 || bus.level !== 3'd0) begin fails++; $display("FAIL ar_valid_level got %b/%0d want 0/0", bus.instr_valid, bus.level); end
    tests++; if (bus.instr !== 8'h00 || bus.instr_pc !== 8'h00) begin fails++; $display("FAIL ar_head got %h/%h want 00/00", bus.instr, bus.instr_pc); end
    tests++; if (bus.pc_out !== 8'h00 || bus.iram_addr !== 8'h00) begin fails++; $display("FAIL ar_pc got %h/%h want 00/00", bus.pc_out, bus.iram_addr); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL ar_latency1 got %b want 0", bus.instr_valid); end
    @(negedge clk);
    tests++; if (bus.instr_valid !== 1'b1 || bus.instr !== iram[0] || bus.instr_pc !== 8'h00) begin fails++; $display("FAIL ar_restart got %b %h/%h want 1 %h/00", bus.instr_valid, bus.instr, bus.instr_pc, iram[0]); end
  endtask

  task automatic test_random();
    logic [7:0] pc = 8'h00;
    fetch_entry_t prev = '0;
    fetch_entry_t got;
    int accepts = 0;
    for (int i = 0; i < 256; i++) iram[i] = 8'($urandom);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.instr_ready = $urandom_range(0, 9) < 7;
      bus.redirect_en = $urandom_range(0, 29) == 0;
      bus.redirect_addr = 8'($urandom);
      got = '{instr: bus.instr, pc: bus.instr_pc};
      tests++; if (bus.instr_valid !== (bus.level != 0) || bus.level > 3'd4) begin fails++; $display("FAIL rnd_level c=%0d valid=%b level=%0d", c, bus.instr_valid, bus.level); end
      if (!bus.instr_valid) begin
        tests++; if (got !== prev) begin fails++; $display("FAIL rnd_hold c=%0d got %h want %h", c, got, prev); end
      end
      if (bus.instr_valid && bus.instr_ready && !bus.redirect_en) begin
        tests++; if (got !== '{instr: iram[pc], pc: pc}) begin fails++; $display("FAIL rnd_data c=%0d got %h/%h want %h/%h", c, got.instr, got.pc, iram[pc], pc); end
        pc++;
        accepts++;
      end
      if (bus.redirect_en) pc = bus.redirect_addr;
      prev = got;
      @(negedge clk);
    end
    bus.redirect_en = 1'b0;
    tests++; if (accepts < 1000) begin fails++; $display("FAIL rnd_throughput got %0d accepts want >=1000", accepts); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    for (int i = 0; i < 256; i++) iram[i] = 8'($urandom);
    test_redirect_flush();
    test_wrap();
    test_redirect_pop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
